// File: rtl/stdout_uart_tx.sv
// stdout_uart_tx: FIFO-buffered 8N1 UART transmitter for the core's stdout, with backpressure on cpu_en.
// Define STDOUT_TX_PARITY_EN to add an even-parity bit after D7 (8E1 framing).
module stdout_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        host_en,
  input  logic [7:0]                  stdout,
  input  logic                        stdout_en,
  output logic                        cpu_en,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_STOP = 3'd3;
`ifdef STDOUT_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd4;
  localparam logic [2:0] S_AFTER_DATA = S_PARITY;
`else
  localparam logic [2:0] S_AFTER_DATA = S_STOP;
`endif
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [LW-1:0] r_level, w_level_n;
  logic [2:0]    r_state, w_state_n;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift, w_shift_n;
  logic          r_tx, w_tx_n, r_busy;
  logic          w_full, w_push, w_pop, w_last;
  assign w_full = r_level == LW'(FIFO_DEPTH);
  assign cpu_en = host_en && !w_full;
  assign w_push = stdout_en && cpu_en;
  assign w_last = r_cnt == CW'(CLKS_PER_BIT - 1);
  // The FSM pops from IDLE or at the final stop-bit cycle, which is what makes back-to-back frames gapless.
  assign w_pop = (r_state == S_IDLE || (r_state == S_STOP && w_last)) && r_level != '0;
  assign w_level_n = r_level + LW'(w_push) - LW'(w_pop);
  assign w_shift_n = w_pop ? r_mem[r_rp] : (r_state == S_DATA && w_last) ? r_shift >> 1 : r_shift;
  assign tx = r_tx;
  assign busy = r_busy;
  assign fifo_level = r_level;
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_IDLE:   w_state_n = w_pop ? S_START : S_IDLE;
      S_START:  w_state_n = w_last ? S_DATA : S_START;
      S_DATA:   w_state_n = (w_last && r_idx == 3'd7) ? S_AFTER_DATA : S_DATA;
`ifdef STDOUT_TX_PARITY_EN
      S_PARITY: w_state_n = w_last ? S_STOP : S_PARITY;
`endif
      S_STOP:   w_state_n = w_last ? (w_pop ? S_START : S_IDLE) : S_STOP;
      default:  w_state_n = S_IDLE;
    endcase
  end
`ifdef STDOUT_TX_PARITY_EN
  logic r_par;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_par <= 1'b0;
    else if (w_pop) r_par <= ^r_mem[r_rp];
  assign w_tx_n = w_state_n == S_START ? 1'b0 : w_state_n == S_DATA ? w_shift_n[0] :
                  w_state_n == S_PARITY ? r_par : 1'b1;
`else
  assign w_tx_n = w_state_n == S_START ? 1'b0 : w_state_n == S_DATA ? w_shift_n[0] : 1'b1;
`endif
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= stdout;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wp <= '0;
      r_rp <= '0;
      r_level <= '0;
      r_state <= S_IDLE;
      r_cnt <= '0;
      r_idx <= '0;
      r_shift <= '0;
      r_tx <= 1'b1;
      r_busy <= 1'b0;
    end else begin
      r_wp <= r_wp + AW'(w_push);
      r_rp <= r_rp + AW'(w_pop);
      r_level <= w_level_n;
      r_state <= w_state_n;
      r_cnt <= (w_state_n != r_state || w_last || r_state == S_IDLE) ? '0 : r_cnt + 1'b1;
      r_idx <= (w_state_n != r_state) ? '0 : r_idx + 3'(r_state == S_DATA && w_last);
      r_shift <= w_shift_n;
      r_tx <= w_tx_n;
      r_busy <= w_state_n != S_IDLE || w_level_n != '0;
    end
  end
endmodule

// File: tb/tb_stdout_uart_tx.sv
// tb_stdout_uart_tx: directed checks of stdout_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=8.
module tb_stdout_uart_tx;
  localparam int CPB = 4;
`ifdef STDOUT_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  logic       clk, reset, host_en, stdout_en, cpu_en, tx, busy;
  logic [7:0] stdout;
  logic [3:0] fifo_level;
  int tests = 0;
  int fails = 0;
  int n;

  stdout_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .host_en(host_en), .stdout(stdout), .stdout_en(stdout_en),
    .cpu_en(cpu_en), .tx(tx), .busy(busy), .fifo_level(fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Finds the start bit, advances skip cycles, then samples every bit CPB cycles apart.
  task automatic recv(input logic [7:0] exp, input int skip);
    logic [7:0] b;
    int w;
    w = 0;
    while (tx !== 1'b0 && w < 400) begin tick(); w++; end
    repeat (skip) tick();
    chk("start_bit", 32'(tx), 0);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) tick();
      b[i] = tx;
    end
`ifdef STDOUT_TX_PARITY_EN
    repeat (CPB) tick();
    chk("parity_bit", 32'(tx), 32'(^exp));
`endif
    repeat (CPB) tick();
    chk("stop_bit", 32'(tx), 1);
    chk("rx_byte", 32'(b), 32'(exp));
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (busy !== 1'b0 && w < 1000) begin tick(); w++; end
    chk("idle", 32'(busy), 0);
  endtask

  initial begin
    reset = 1'b1; host_en = 1'b1; stdout_en = 1'b0; stdout = '0;
    tick(); tick();
    chk("rst_tx", 32'(tx), 1);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cpu_en", 32'(cpu_en), 1);
    reset = 1'b0;
    tick();

    host_en = 1'b0;
    #1;
    chk("hosten0_cpu_en", 32'(cpu_en), 0);
    stdout = 8'h21; stdout_en = 1'b1;
    repeat (3) tick();
    chk("hosten0_level", 32'(fifo_level), 0);
    chk("hosten0_busy", 32'(busy), 0);
    chk("hosten0_tx", 32'(tx), 1);
    stdout_en = 1'b0; host_en = 1'b1;
    #1;
    chk("hosten1_cpu_en", 32'(cpu_en), 1);
    tick();

    stdout = 8'h41; stdout_en = 1'b1;
    tick();
    stdout_en = 1'b0;
    chk("push_level", 32'(fifo_level), 1);
    chk("push_busy", 32'(busy), 1);
    chk("push_tx", 32'(tx), 1);
    tick();
    chk("pop_tx", 32'(tx), 0);
    chk("pop_level", 32'(fifo_level), 0);
    recv(8'h41, 2);
    tick();
    chk("busy_before_end", 32'(busy), 1);
    tick();
    chk("busy_fall", 32'(busy), 0);
    chk("idle_tx", 32'(tx), 1);
    tick(); tick();

    stdout = 8'h55; stdout_en = 1'b1;
    tick();
    stdout_en = 1'b0;
    repeat (3) tick();
    stdout = 8'hAA; stdout_en = 1'b1;
    tick();
    stdout_en = 1'b0;
    recv(8'h55, 0);
    tick();
    chk("b2b_no_gap", 32'(tx), 0);
    recv(8'hAA, 2);
    wait_idle();

    stdout = 8'h2F; stdout_en = 1'b1;
    tick();
    stdout_en = 1'b0;
    tick(); tick();
    chk("bp_level0", 32'(fifo_level), 0);
    for (int k = 0; k < 9; k++) begin
      stdout = 8'(8'h30 + k); stdout_en = 1'b1;
      n = 0;
      while (!cpu_en && n < 100) begin
        chk("bp_hold_level", 32'(fifo_level), 8);
        tick();
        n++;
      end
      tick();
      if (k == 7) begin
        chk("bp_full", 32'(fifo_level), 8);
        chk("bp_cpu_en_low", 32'(cpu_en), 0);
      end
    end
    stdout_en = 1'b0;
    chk("bp_accept_once", 32'(fifo_level), 8);
    tick();
    chk("bp_level_stable", 32'(fifo_level), 8);
    recv(8'h30, 1);
    for (int k = 1; k < 9; k++) recv(8'(8'h30 + k), 2);
    wait_idle();

`ifdef STDOUT_TX_PARITY_EN
    stdout = 8'h07; stdout_en = 1'b1;
    tick();
    stdout_en = 1'b0;
    tick();
    recv(8'h07, 2);
    tick();
    chk("par_busy_before_end", 32'(busy), 1);
    tick();
    chk("par_busy_fall", 32'(busy), 0);
    stdout = 8'h03; stdout_en = 1'b1;
    tick();
    stdout_en = 1'b0;
    tick();
    recv(8'h03, 2);
    wait_idle();
`endif

    stdout = 8'hFF; stdout_en = 1'b1;
    tick();
    stdout = 8'h11;
    tick();
    stdout = 8'h22;
    tick();
    stdout_en = 1'b0;
    repeat (16) tick();
    chk("mid_level", 32'(fifo_level), 2);
    chk("mid_busy", 32'(busy), 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_tx", 32'(tx), 1);
    chk("arst_level", 32'(fifo_level), 0);
    chk("arst_busy", 32'(busy), 0);
    tick(); tick();
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0) n++;
    end
    chk("post_rst_quiet", 32'(n), 0);
    chk("post_rst_level", 32'(fifo_level), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
